// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 16x2 write-only controller with 32-byte char buffer.
// Ports: SYS_clk/SYS_rst, wr_en/wr_addr/wr_data buffer write,
//   init_done/frame_done status, LCD_DATA/EN/RS/RW/ON pins.
// Option: LCD_CTRL_DIRTY_EN idles between frames until a write.
module lcd_ctrl #(
  parameter int INIT_WAIT  = 750000,
  parameter int EN_CYCLES  = 12,
  parameter int CMD_WAIT   = 2500,
  parameter int CLEAR_WAIT = 82000
) (
  input  logic       SYS_clk,
  input  logic       SYS_rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       frame_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_ON
);

  localparam int MAXW =
    (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
  localparam int CW = $clog2(MAXW + 1);

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] EN_LAST   = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_WAIT - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, ADDR1, LINE1, ADDR2, LINE2, IDLE
  } top_t;

  typedef enum logic [1:0] {
    SETUP, PULSE, HOLD
  } ph_t;

  top_t          top_q, top_d;
  ph_t           ph_q, ph_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hold_last;
  logic [7:0]    data_q;
  logic          rs_q;
  logic          init_q;
  logic [7:0]    mem_q [32];
  logic          start;
  logic          frame_end;
  logic [7:0]    pay_data;
  logic          pay_rs;
  logic          dirty_q;

  // Only the clear command (third init step) needs the long wait.
  always_comb begin
    hold_last = CMD_LAST;
    if (top_q == INIT && idx_q == 4'd2) hold_last = CLR_LAST;
  end

  always_comb begin
    top_d     = top_q;
    ph_d      = ph_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    start     = 1'b0;
    frame_end = 1'b0;
    unique case (top_q)
      PWR_WAIT: begin
        if (cnt_q == INIT_LAST) begin
          top_d = INIT;
          idx_d = 4'd0;
          start = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      IDLE: begin
        if (dirty_q) begin
          top_d = ADDR1;
          idx_d = 4'd0;
          start = 1'b1;
        end
      end
      default: begin
        unique case (ph_q)
          SETUP: begin
            ph_d  = PULSE;
            cnt_d = '0;
          end
          PULSE: begin
            if (cnt_q == EN_LAST) begin
              ph_d  = HOLD;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
          HOLD: begin
            if (cnt_q != hold_last) begin
              cnt_d = cnt_q + ONE;
            end else begin
              start = 1'b1;
              idx_d = idx_q + 4'd1;
              unique case (top_q)
                INIT: begin
                  if (idx_q == 4'd3) begin
                    top_d = ADDR1;
                    idx_d = 4'd0;
                  end
                end
                ADDR1: begin
                  top_d = LINE1;
                  idx_d = 4'd0;
                end
                LINE1: begin
                  if (idx_q == 4'd15) begin
                    top_d = ADDR2;
                    idx_d = 4'd0;
                  end
                end
                ADDR2: begin
                  top_d = LINE2;
                  idx_d = 4'd0;
                end
                default: begin
                  if (idx_q == 4'd15) begin
                    top_d     = ADDR1;
                    idx_d     = 4'd0;
                    frame_end = 1'b1;
`ifdef LCD_CTRL_DIRTY_EN
                    if (!dirty_q) begin
                      top_d = IDLE;
                      start = 1'b0;
                    end
`endif
                  end
                end
              endcase
            end
          end
          default: ;
        endcase
      end
    endcase
    if (start) begin
      ph_d  = SETUP;
      cnt_d = '0;
    end
  end

  // Payload of the transaction being entered; mem_q is the
  // pre-write value when a write lands on the same edge.
  always_comb begin
    pay_data = 8'h00;
    pay_rs   = 1'b0;
    unique case (top_d)
      INIT: begin
        unique case (idx_d[1:0])
          2'd0: pay_data = 8'h38;
          2'd1: pay_data = 8'h0C;
          2'd2: pay_data = 8'h01;
          default: pay_data = 8'h06;
        endcase
      end
      ADDR1: pay_data = 8'h80;
      ADDR2: pay_data = 8'hC0;
      LINE1, LINE2: begin
        pay_data = mem_q[{top_d == LINE2, idx_d}];
        pay_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      top_q  <= PWR_WAIT;
      ph_q   <= SETUP;
      idx_q  <= '0;
      cnt_q  <= '0;
      data_q <= 8'h00;
      rs_q   <= 1'b0;
      init_q <= 1'b0;
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
    end else begin
      top_q <= top_d;
      ph_q  <= ph_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      if (start) begin
        data_q <= pay_data;
        rs_q   <= pay_rs;
        if (top_d == ADDR1) init_q <= 1'b1;
      end
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end
  end

`ifdef LCD_CTRL_DIRTY_EN
  // A write on the frame-start edge keeps dirty set.
  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      dirty_q <= 1'b0;
    end else if (wr_en) begin
      dirty_q <= 1'b1;
    end else if (start && top_d == ADDR1) begin
      dirty_q <= 1'b0;
    end
  end
`else
  assign dirty_q = 1'b0;
`endif

  assign LCD_EN     = (ph_q == PULSE);
  assign LCD_DATA   = data_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_ON     = 1'b1;
  assign init_done  = init_q;
  assign frame_done = frame_end;

endmodule
